// File: rtl/i2s_tx_feeder.sv
// rtl/i2s_tx_feeder.sv - Sample buffer that feeds PCM words into the I2S Tx data register over APB,
// polling the Tx_full status flag before every write.
module i2s_tx_feeder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] TX_OFS    = 32'h4,
    parameter logic [31:0] STAT_OFS  = 32'h8,
    parameter int unsigned FULL_BIT  = 7,
    parameter int unsigned MAX_POLLS = 255
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     enable,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_data,
    output logic [31:0]              paddr,
    output logic                     pwrite,
    output logic                     penable,
    output logic [31:0]              pwdata,
    input  logic [31:0]              prdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     stall
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0]  MAX_POLLS_C = 8'(MAX_POLLS);
    localparam logic [31:0] STAT_ADDR   = BASE_ADDR + STAT_OFS;
    localparam logic [31:0] TX_ADDR     = BASE_ADDR + TX_OFS;

    typedef enum logic [2:0] {
        IDLE, POLL_SETUP, POLL_ACCESS, CHECK, WR_SETUP, WR_ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push, pop;
    logic            full_q;
    logic [7:0]      poll_cnt_q, poll_cnt_d;
    logic            stall_q, stall_d;
    logic [31:0]     paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d, penable_q, penable_d;
    logic            prdata_unused;

    assign prdata_unused = ^prdata;

    assign s_ready = (count_q < (AW+1)'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == WR_ACCESS);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        stall_d    = stall_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        penable_d  = 1'b0;
        case (state_q)
            IDLE:        if (enable && count_q != '0) state_d = POLL_SETUP;
            POLL_SETUP:  state_d = POLL_ACCESS;
            POLL_ACCESS: state_d = CHECK;
            CHECK: begin
                if (full_q) begin
                    if (poll_cnt_q != MAX_POLLS_C) poll_cnt_d = poll_cnt_q + 8'd1;
                    if (poll_cnt_d == MAX_POLLS_C) stall_d = 1'b1;
                    state_d = enable ? POLL_SETUP : IDLE;
                end else begin
                    state_d = WR_SETUP;
                end
            end
            WR_SETUP:    state_d = WR_ACCESS;
            WR_ACCESS: begin
                poll_cnt_d = 8'd0;
                stall_d    = 1'b0;
                state_d    = (enable && count_d != '0) ? POLL_SETUP : IDLE;
            end
            default:     state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are loaded for the state being entered.
        case (state_d)
            IDLE:        pwrite_d = 1'b0;
            POLL_SETUP: begin
                paddr_d  = STAT_ADDR;
                pwrite_d = 1'b0;
            end
            WR_SETUP: begin
                paddr_d  = TX_ADDR;
                pwrite_d = 1'b1;
                pwdata_d = mem_q[rd_ptr_q];
            end
            POLL_ACCESS, WR_ACCESS: penable_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            full_q     <= 1'b0;
            poll_cnt_q <= 8'd0;
            stall_q    <= 1'b0;
            paddr_q    <= 32'd0;
            pwrite_q   <= 1'b0;
            penable_q  <= 1'b0;
            pwdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            if (state_q == POLL_ACCESS) full_q <= prdata[FULL_BIT];
            poll_cnt_q <= poll_cnt_d;
            stall_q    <= stall_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            penable_q  <= penable_d;
            pwdata_q   <= pwdata_d;
        end
    end

    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign penable = penable_q;
    assign pwdata  = pwdata_q;
    assign level   = count_q;
    assign busy    = (state_q != IDLE);
    assign stall   = stall_q;
endmodule
